// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, byte/half/word lane steering,
// and a registered response issued a fixed number of wait states after acceptance.
module data_mem_responder #(
  parameter int    ADDR_BITS   = 14,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << (ADDR_BITS - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  size_t                  size_q;
  logic                   uns_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q;

  // NOTE: storage has no reset; contents survive rst and start as X.
  logic [31:0]            mem [DEPTH];

  // Address bits above ADDR_BITS alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS];

  logic [ADDR_BITS-3:0] idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic                 err;
  logic                 wr_en;

  assign idx       = addr_q[ADDR_BITS-1:2];
  assign lane      = addr_q[1:0];
  assign rd_word   = mem[idx];
  assign err       = (size_q == SZ_RSVD)
                   || ((size_q == SZ_WORD) && (lane != 2'b00))
                   || ((size_q == SZ_HALF) && lane[0]);
  assign wr_en     = (state == S_RESP) && we_q && !err;
  assign req_ready = (state == S_IDLE) && !rst;

  // Load extraction: pick the addressed byte/half, then extend.
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    load_data = rd_word;
    byte_sel  = rd_word[{lane, 3'b000} +: 8];
    half_sel  = rd_word[{lane[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store merge: replicate the right-justified data and enable only the target lanes.
  logic [3:0]  byte_en;
  logic [31:0] wrep;
  logic [31:0] merged;

  always_comb begin
    byte_en = 4'b0000;
    wrep    = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wrep    = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{wdata_q[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byte_en[i] ? wrep[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // A reset on the write edge discards the store along with the transaction.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= SZ_WORD;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q    <= req_we;
            size_q  <= size_t'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[ADDR_BITS-1:0];
            wdata_q <= req_wdata;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || we_q) ? 32'h0 : load_data;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3 and 0 wait states) checked against
// a byte-addressed reference memory with directed and random transactions.
module tb_data_mem_responder;

  localparam int NDUT  = 3;
  localparam int AMASK = (1 << 14) - 1;

  function automatic int ws_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 0;
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [NDUT];
  logic        req_valid    [NDUT];
  logic        req_ready    [NDUT];
  logic        req_we       [NDUT];
  logic [1:0]  req_size     [NDUT];
  logic        req_unsigned [NDUT];
  logic [31:0] req_addr     [NDUT];
  logic [31:0] req_wdata    [NDUT];
  logic        rsp_valid    [NDUT];
  logic [31:0] rsp_rdata    [NDUT];
  logic        rsp_err      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder #(.ADDR_BITS(14), .WAIT_STATES(ws_of(g)), .INIT_FILE("")) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  // Reference memory: one byte per aliased byte address, per instance.
  logic [7:0] mm [NDUT][AMASK+1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request: predicts the response from the reference memory, drives the
  // handshake, and checks latency, error flag, data, pulse width and data hold.
  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input string tag,
                     output logic [31:0] got, output logic got_err);
    int          n;
    int          k;
    logic        exp_err;
    logic [31:0] exp_rd;
    n       = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    exp_err = (sz == 2'b11) || (sz == 2'b00 && addr[1:0] != 2'b00) || (sz == 2'b10 && addr[0]);
    exp_rd  = 32'h0;
    got     = 32'hx;
    got_err = 1'bx;
    if (!exp_err && !we) begin
      for (int i = 0; i < n; i++) exp_rd |= {24'h0, mm[d][(int'(addr) + i) & AMASK]} << (8 * i);
      if (!uns && n < 4 && exp_rd[8*n-1]) begin
        for (int i = n; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
      end
    end
    if (!exp_err && we) begin
      for (int i = 0; i < n; i++) mm[d][(int'(addr) + i) & AMASK] = wd[8*i +: 8];
    end

    @(negedge clk);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[d]) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;

    @(negedge clk);
    k = 1;
    while (!rsp_valid[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid[d]) begin
      check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      return;
    end
    got     = rsp_rdata[d];
    got_err = rsp_err[d];
    check({tag, "_latency"}, 32'(k - 1), 32'(ws_of(d) + 1));
    check({tag, "_err"}, {31'h0, rsp_err[d]}, {31'h0, exp_err});
    check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, rsp_valid[d]}, 32'd0);
    check({tag, "_hold"}, rsp_rdata[d], exp_rd);
  endtask

  logic [31:0] got;
  logic        got_err;
  int          acc[$];
  logic        seen;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d]          = 1'b1;
      req_valid[d]    = 1'b1;
      req_we[d]       = 1'b0;
      req_size[d]     = 2'b00;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = 32'h0;
      req_wdata[d]    = 32'h0;
    end

    // Reset held three cycles with a request pending.
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("rst_ready%0d", d), {31'h0, req_ready[d]}, 32'd0);
        check($sformatf("rst_valid%0d", d), {31'h0, rsp_valid[d]}, 32'd0);
        check($sformatf("rst_rdata%0d", d), rsp_rdata[d], 32'd0);
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      rst[d]       = 1'b0;
      req_valid[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check($sformatf("post_rst_ready%0d", d), {31'h0, req_ready[d]}, 32'd1);

    // Word round trip and lane steering, one wait state.
    txn(0, 1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, "st_word", got, got_err);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, "ld_word", got, got_err);
    check("ld_word_const", got, 32'hDEADBEEF);
    txn(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h00000055, "st_byte", got, got_err);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, "ld_merged", got, got_err);
    check("ld_merged_const", got, 32'hDE55BEEF);
    txn(0, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, "ld_sbyte", got, got_err);
    check("ld_sbyte_const", got, 32'hFFFFFFDE);
    txn(0, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, "ld_ubyte", got, got_err);
    check("ld_ubyte_const", got, 32'h000000DE);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "ld_shalf", got, got_err);
    check("ld_shalf_const", got, 32'hFFFFBEEF);

    // Misaligned and reserved-size requests.
    txn(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, "st_mis", got, got_err);
    check("st_mis_err_const", {31'h0, got_err}, 32'd1);
    check("st_mis_rdata_const", got, 32'd0);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, "ld_after_mis", got, got_err);
    check("ld_after_mis_const", got, 32'hDE55BEEF);
    txn(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, "ld_rsvd", got, got_err);
    check("ld_rsvd_err_const", {31'h0, got_err}, 32'd1);

    // Three wait states: continuous req_valid is accepted once every five cycles.
    txn(1, 1'b1, 2'b00, 1'b0, 32'h100, 32'h11223344, "w3_init", got, got_err);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_size[1]  = 2'b00;
    req_addr[1]  = 32'h100;
    for (int c = 0; c < 25; c++) begin
      if (req_ready[1]) acc.push_back(c);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("hs_count", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++) check("hs_gap", 32'(acc[i] - acc[i-1]), 32'd5);

    // Reset during the wait of a store: no response, old data kept.
    txn(1, 1'b1, 2'b00, 1'b0, 32'h200, 32'h0BADC0DE, "w3_st200", got, got_err);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_size[1]  = 2'b00;
    req_addr[1]  = 32'h200;
    req_wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    check("rst_abort_rsp", {31'h0, seen}, 32'd0);
    txn(1, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, "w3_ld200", got, got_err);
    check("w3_ld200_const", got, 32'h0BADC0DE);

    // Zero wait states with address aliasing.
    txn(2, 1'b1, 2'b00, 1'b0, 32'h4010, 32'hA5A5A5A5, "w0_st_alias", got, got_err);
    txn(2, 1'b0, 2'b00, 1'b0, 32'h0010, 32'h0, "w0_ld_alias", got, got_err);
    check("w0_ld_alias_const", got, 32'hA5A5A5A5);

    // Random traffic over an initialised window, with aliased addresses mixed in.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 16; w++) begin
        txn(d, 1'b1, 2'b00, 1'b0, 32'h300 + 32'(4 * w), $urandom, "rnd_init", got, got_err);
      end
      for (int t = 0; t < 40; t++) begin
        txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h300 + 32'($urandom_range(0, 63)) + 32'(32'h4000 * $urandom_range(0, 3)),
            $urandom, $sformatf("rnd%0d_%0d", d, t), got, got_err);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
